// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done bundle between a requester (master) and the bin_to_bcd_seq converter (slave).
// state_dbg exposes the converter FSM state (0 = IDLE, 1 = SHIFT) for checkers.
interface bin_to_bcd_seq_if #(
  parameter int IN_W       = 8,
  parameter int OUT_DIGITS = 2
);
  // Handshake: start is honoured only on an edge where busy is low (IDLE or the
  // done cycle); bin_in is captured on that edge; done pulses one cycle when
  // bcd_out/overflow have been updated, and those hold until the next done.
  logic                    start;
  logic [IN_W-1:0]         bin_in;
  logic                    busy;
  logic                    done;
  logic [4*OUT_DIGITS-1:0] bcd_out;
  logic                    overflow;
  logic                    state_dbg;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow, state_dbg
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow, state_dbg
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SAT_EN to saturate bcd_out to all nines when overflow is set.
module bin_to_bcd_seq #(
  parameter int IN_W       = 8,
  parameter int OUT_DIGITS = 2
) (
  input logic             clk,
  input logic             rst,
  bin_to_bcd_seq_if.slave bus
);

  localparam int SCR_D = (IN_W + 2) / 3 + 1;
  localparam int SCR_W = 4 * SCR_D;
  localparam int OUT_W = 4 * OUT_DIGITS;
  localparam int CW    = $clog2(IN_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0]     MAX_DEC = pow10(OUT_DIGITS) - 64'd1;
  // If every IN_W-bit value fits in the displayed digits, overflow can never occur.
  localparam bit              OVF_ON  = (MAX_DEC < (64'd1 << IN_W));
  localparam logic [IN_W-1:0] MAX_IN  = MAX_DEC[IN_W-1:0];

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_nxt;
  logic [IN_W-1:0]  shift_q, shift_nxt;
  logic [SCR_W-1:0] scratch_q, scratch_nxt;
  logic [CW-1:0]    count_q, count_nxt;
  logic             pend_q, pend_nxt;
  logic [OUT_W-1:0] bcd_q, bcd_nxt;
  logic             ovf_q, ovf_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;

  logic [SCR_W-1:0] adj;
  logic [SCR_W-1:0] scr_shf;
  logic [IN_W-1:0]  shf_shf;
  logic [OUT_W-1:0] res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      shift_q   <= shift_nxt;
      scratch_q <= scratch_nxt;
      count_q   <= count_nxt;
      pend_q    <= pend_nxt;
      bcd_q     <= bcd_nxt;
      ovf_q     <= ovf_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    shift_nxt   = shift_q;
    scratch_nxt = scratch_q;
    count_nxt   = count_q;
    pend_nxt    = pend_q;
    bcd_nxt     = bcd_q;
    ovf_nxt     = ovf_q;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
    adj         = scratch_q;
    res         = '0;

    for (int d = 0; d < SCR_D; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
    end
    {scr_shf, shf_shf} = {adj, shift_q} << 1;

    // Only the low OUT_DIGITS digits are presented; higher digits are scratch only.
    for (int i = 0; i < OUT_DIGITS; i++) begin
      if (i < SCR_D) res[4*i +: 4] = scr_shf[4*i +: 4];
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_nxt   = bus.bin_in;
          scratch_nxt = '0;
          count_nxt   = CW'(IN_W);
          pend_nxt    = OVF_ON && (bus.bin_in > MAX_IN);
          busy_nxt    = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_nxt = scr_shf;
        shift_nxt   = shf_shf;
        count_nxt   = count_q - 1'b1;
        if (count_q == CW'(1)) begin
`ifdef BIN2BCD_SAT_EN
          bcd_nxt   = pend_q ? {OUT_DIGITS{4'h9}} : res;
`else
          bcd_nxt   = res;
`endif
          ovf_nxt   = pend_q;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.overflow  = ovf_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (IN_W=8, OUT_DIGITS=2): directed corner cases plus
// randomized back-to-back conversions scored against an arithmetic decimal model.
module tb_bin_to_bcd_seq;

  localparam int IN_W       = 8;
  localparam int OUT_DIGITS = 2;
  localparam int LAT        = IN_W;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  logic [8:0] exp_q[$];

  bin_to_bcd_seq_if #(.IN_W(IN_W), .OUT_DIGITS(OUT_DIGITS)) bus ();

  bin_to_bcd_seq #(.IN_W(IN_W), .OUT_DIGITS(OUT_DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: decimal digits by plain division, {overflow, bcd}
  function automatic logic [8:0] model(input int v);
    logic       ovf;
    logic [7:0] bcd;
    ovf = (v > 99);
    bcd = {4'((v / 10) % 10), 4'(v % 10)};
`ifdef BIN2BCD_SAT_EN
    if (ovf) bcd = 8'h99;
`endif
    return {ovf, bcd};
  endfunction

  // driver: present start for one edge, record the expected result
  task automatic start_conv(input logic [7:0] v);
    @(negedge clk);
    bus.bin_in = v;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.bin_in = $urandom_range(0, 255);
    exp_q.push_back(model(int'(v)));
    check("busy_after_start", bus.busy, 1'b1);
  endtask

  // waits for done; lat = edges expected from now until done is seen
  task automatic wait_done(input string tag, input int lat);
    int   n;
    logic seen;
    logic [8:0] e;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3 * LAT) begin
      @(posedge clk);
      #1;
      n++;
      seen = bus.done;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      check({tag, "_latency"}, n, lat);
      check({tag, "_busy_low"}, bus.busy, 1'b0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_bcd"}, bus.bcd_out, e[7:0]);
        check({tag, "_ovf"}, bus.overflow, e[8]);
      end else begin
        check({tag, "_exp_q_empty"}, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic conv(input string tag, input logic [7:0] v);
    start_conv(v);
    wait_done(tag, LAT);
  endtask

  initial begin
    logic seen_any;
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.bin_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_bcd", bus.bcd_out, 8'h00);
    check("rst_ovf", bus.overflow, 1'b0);
    check("rst_state", bus.state_dbg, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // directed values and boundaries
    conv("t2a", 8'h2A);
    @(posedge clk);
    #1;
    check("done_single_cycle", bus.done, 1'b0);
    check("bcd_held", bus.bcd_out, 8'h42);
    conv("t00", 8'h00);
    conv("t63", 8'h63);
    conv("t64", 8'h64);
    conv("t63b", 8'h63);
    conv("tff", 8'hFF);
    conv("t0a", 8'h0A);

    // start while busy is ignored, and not queued
    start_conv(8'h11);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 8'h77;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = 8'hEE;
    wait_done("busy_ign", LAT - 1);
    seen_any = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen_any = seen_any | bus.done | bus.busy;
    end
    check("no_queued_start", seen_any, 1'b0);

    // start held during the done cycle is accepted
    start_conv(8'h30);
    wait_done("b2b_first", LAT);
    @(negedge clk);
    check("start_in_done_cycle", bus.done, 1'b1);
    bus.bin_in = 8'h07;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.bin_in = 8'hC8;
    exp_q.push_back(model(7));
    wait_done("b2b_second", LAT);

    // reset at the 4th shift cycle aborts without done
    start_conv(8'h33);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_bcd", bus.bcd_out, 8'h00);
    check("mid_rst_ovf", bus.overflow, 1'b0);
    check("mid_rst_state", bus.state_dbg, 1'b0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    seen_any = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen_any = seen_any | bus.done;
    end
    check("no_done_after_rst", seen_any, 1'b0);
    conv("t5a", 8'h5A);

    // randomized back-to-back conversions
    for (int i = 0; i < 40; i++) begin
      conv("rand", 8'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
